key_debounce_repeat: RTL and testbench

Front-end button conditioner for the five EGo1 push-buttons, sitting directly upstream of the clock/stopwatch controller. Synchronizes and debounces the raw `key[4:0]` vector and emits a one-cycle, registered key code on `key_data`, which the controller consumes as a command. Held adjust keys auto-repeat, so hour/min/sec can be ramped without repeated presses. Simultaneous presses are rejected, and a new press is locked out until a full, debounced release.

---
 rtl/key_debounce_repeat_pkg.sv | 38 +++
 rtl/key_debounce_repeat_sync_2ff.sv | 31 +++
 rtl/key_debounce_repeat.sv | 147 ++++++++++++++
 tb/tb_key_debounce_repeat.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/key_debounce_repeat_pkg.sv
// Shared definitions for the push-button conditioner: key codes, FSM states
// and the one-hot to key-code mapping.
package key_pkg;

  localparam logic [2:0] KEY_NONE = 3'd0;
  localparam logic [2:0] KEY_MODE = 3'd1;
  localparam logic [2:0] KEY_DEC  = 3'd2;
  localparam logic [2:0] KEY_SEL  = 3'd3;
  localparam logic [2:0] KEY_S3   = 3'd4;
  localparam logic [2:0] KEY_INC  = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    REPEAT,
    RELEASE
  } key_state_e;

  function automatic logic [2:0] onehot2code(input logic [4:0] oh);
    logic [2:0] code;
    code = KEY_NONE;
    case (oh)
      5'b00001: code = KEY_MODE;
      5'b00010: code = KEY_DEC;
      5'b00100: code = KEY_SEL;
      5'b01000: code = KEY_S3;
      5'b10000: code = KEY_INC;
      default:  code = KEY_NONE;
    endcase
    return code;
  endfunction

  function automatic logic is_onehot(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

endpackage

// File: rtl/key_debounce_repeat_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, async active-low reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_debounce_repeat.sv
// Debounces the five push-buttons, rejects chords, and emits one-cycle key
// codes with auto-repeat for the keys selected by REPEAT_MASK.
//
//   state    | meaning
//   IDLE     | no key accepted, waiting for a one-hot pattern
//   DEBOUNCE | candidate seen, counting stable cycles before accepting
//   HELD     | press accepted, counting toward first auto-repeat
//   REPEAT   | auto-repeating every REP_CYC cycles
//   RELEASE  | lockout until DEB_CYC cycles of all keys released
module key_debounce_repeat
  import key_pkg::*;
#(
  parameter int         DEB_CYC     = 2_000_000,
  parameter int         HOLD_CYC    = 50_000_000,
  parameter int         REP_CYC     = 10_000_000,
  parameter logic [4:0] REPEAT_MASK = 5'b10010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key,
  output logic [2:0] key_data,
  output logic       key_repeat,
  output logic       key_held
);

  localparam int CNT_W = $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

  logic [4:0]       ks;
  key_state_e       state_q, state_d;
  logic [4:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       key_data_q, key_data_d;
  logic             key_repeat_q, key_repeat_d;
  logic             key_held_q, key_held_d;
  logic             same;

  sync_2ff #(.WIDTH(5)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key),
    .q   (ks)
  );

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    key_data_d   = KEY_NONE;
    key_repeat_d = 1'b0;
    cnt_inc      = cnt_q + CNT_W'(1);
    same         = (ks == cand_q);

    case (state_q)
      IDLE: begin
        if (is_onehot(ks)) begin
          cand_d  = ks;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!same) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          key_data_d = onehot2code(cand_q);
          cnt_d      = '0;
          state_d    = HELD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!same) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end else if (cnt_q == HOLD_LAST) begin
          // Non-repeating keys park here with the count saturated.
          if ((cand_q & REPEAT_MASK) != 5'd0) begin
            key_data_d   = onehot2code(cand_q);
            key_repeat_d = 1'b1;
            cnt_d        = '0;
            state_d      = REPEAT;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REPEAT: begin
        if (!same) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end else if (cnt_q == REP_LAST) begin
          key_data_d   = onehot2code(cand_q);
          key_repeat_d = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE: begin
        if (ks != 5'd0) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          cand_d  = 5'd0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cand_d  = 5'd0;
        cnt_d   = '0;
      end
    endcase

    key_held_d = (state_d == HELD) || (state_d == REPEAT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cand_q       <= 5'd0;
      cnt_q        <= '0;
      key_data_q   <= KEY_NONE;
      key_repeat_q <= 1'b0;
      key_held_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      key_data_q   <= key_data_d;
      key_repeat_q <= key_repeat_d;
      key_held_q   <= key_held_d;
    end
  end

  assign key_data   = key_data_q;
  assign key_repeat = key_repeat_q;
  assign key_held   = key_held_q;

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Directed bench for key_debounce_repeat with short timing parameters
// (DEB_CYC=4, HOLD_CYC=20, REP_CYC=8); a key driven just after a clock edge
// produces its press event in the 7th cycle after that edge.
module tb_key_debounce_repeat;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] key;
  logic [2:0] key_data;
  logic       key_repeat;
  logic       key_held;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_debounce_repeat #(
    .DEB_CYC     (4),
    .HOLD_CYC    (20),
    .REP_CYC     (8),
    .REPEAT_MASK (5'b10010)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .key_data   (key_data),
    .key_repeat (key_repeat),
    .key_held   (key_held)
  );

  task automatic chk(input string tag, input logic [2:0] ed, input logic er, input logic eh);
    checks++;
    assert (key_data === ed) else begin
      errors++;
      $error("FAIL %s key_data=%0d expected %0d", tag, key_data, ed);
    end
    checks++;
    assert (key_repeat === er) else begin
      errors++;
      $error("FAIL %s key_repeat=%0b expected %0b", tag, key_repeat, er);
    end
    checks++;
    assert (key_held === eh) else begin
      errors++;
      $error("FAIL %s key_held=%0b expected %0b", tag, key_held, eh);
    end
  endtask

  task automatic tick_chk(input string tag, input logic [2:0] ed, input logic er, input logic eh);
    @(posedge clk);
    #1;
    chk(tag, ed, er, eh);
  endtask

  // Drop all keys; key_held (if it was up) stays high for two more cycles,
  // then the lockout runs out well inside the ten observed cycles.
  task automatic release_phase(input string tag, input logic was_held);
    key = 5'd0;
    for (int j = 1; j <= 10; j++)
      tick_chk($sformatf("%s_rel%0d", tag, j), 3'd0, 1'b0, was_held && (j < 3));
  endtask

  initial begin
    rst = 1'b0;
    key = 5'd0;
    #2;
    chk("reset_async", 3'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 1; i <= 4; i++)
      tick_chk($sformatf("idle%0d", i), 3'd0, 1'b0, 1'b0);

    // S2 (code 3) is not in the repeat mask: one event, no repeat past HOLD_CYC.
    key = 5'b00100;
    for (int i = 1; i <= 30; i++)
      tick_chk($sformatf("sel%0d", i), (i == 7) ? 3'd3 : 3'd0, 1'b0, i >= 7);
    release_phase("sel", 1'b1);

    // S4 (code 5) repeats 20 cycles after the press event, then every 8.
    key = 5'b10000;
    for (int i = 1; i <= 60; i++) begin
      logic rp;
      rp = (i >= 27) && (((i - 27) % 8) == 0);
      tick_chk($sformatf("inc%0d", i), (i == 7 || rp) ? 3'd5 : 3'd0, rp, i >= 7);
    end
    release_phase("inc", 1'b1);

    // Bounce: 3 cycles pressed, 1 released, then solid.
    key = 5'b00010;
    for (int i = 1; i <= 3; i++)
      tick_chk($sformatf("bnc_a%0d", i), 3'd0, 1'b0, 1'b0);
    key = 5'b00000;
    tick_chk("bnc_gap", 3'd0, 1'b0, 1'b0);
    key = 5'b00010;
    for (int i = 1; i <= 12; i++)
      tick_chk($sformatf("bnc%0d", i), (i == 7) ? 3'd2 : 3'd0, 1'b0, i >= 7);
    release_phase("bnc", 1'b1);

    // Multi-hot pattern is never accepted.
    key = 5'b00011;
    for (int i = 1; i <= 30; i++)
      tick_chk($sformatf("multi%0d", i), 3'd0, 1'b0, 1'b0);
    release_phase("multi", 1'b0);

    // Chord on top of a held key: lockout, then a clean press after release.
    key = 5'b00001;
    for (int i = 1; i <= 10; i++)
      tick_chk($sformatf("mode%0d", i), (i == 7) ? 3'd1 : 3'd0, 1'b0, i >= 7);
    key = 5'b01001;
    for (int i = 1; i <= 5; i++)
      tick_chk($sformatf("chord%0d", i), 3'd0, 1'b0, i < 3);
    key = 5'b00000;
    for (int i = 1; i <= 4; i++)
      tick_chk($sformatf("gap%0d", i), 3'd0, 1'b0, 1'b0);
    key = 5'b01000;
    for (int i = 1; i <= 10; i++)
      tick_chk($sformatf("s3_%0d", i), (i == 7) ? 3'd4 : 3'd0, 1'b0, i >= 7);
    release_phase("s3", 1'b1);

    // Reset in the cycle a repeat event is on the outputs, key still held.
    key = 5'b10000;
    for (int i = 1; i <= 27; i++) begin
      logic rp;
      rp = (i == 27);
      tick_chk($sformatf("pre_rst%0d", i), (i == 7 || rp) ? 3'd5 : 3'd0, rp, i >= 7);
    end
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_repeat", 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_mid_hold", 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 1; i <= 10; i++)
      tick_chk($sformatf("post_rst%0d", i), (i == 7) ? 3'd5 : 3'd0, 1'b0, i >= 7);
    release_phase("post_rst", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
